jk_counter_reg: RTL and testbench

JK_COUNTER_REG -- requirements
Module: jk_counter_reg

---
 rtl/jk_counter_reg.sv | 86 ++++++++
 tb/tb_jk_counter_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/jk_counter_reg.sv
// JK / load / up-down counter / shift register with carry pulse,
// serial output and a sticky wrap (overflow) flag.
module jk_counter_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             carry,
    output logic             ser_out,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH-1:0] q_next;
    logic             wrap;
    logic             shift;
    logic             shift_bit;

    always_comb begin
        q_next    = q;
        wrap      = 1'b0;
        shift     = 1'b0;
        shift_bit = 1'b0;
        unique case (mode)
            3'b000: q_next = (j & ~q) | (~k & q);
            3'b001: q_next = d;
            3'b010: begin
                q_next = q + 1'b1;
                wrap   = &q;
            end
            3'b011: begin
                q_next = q - 1'b1;
                wrap   = ~|q;
            end
            3'b100: begin
                q_next    = {q[WIDTH-2:0], ser_in};
                shift     = 1'b1;
                shift_bit = q[WIDTH-1];
            end
            3'b101: begin
                q_next    = {ser_in, q[WIDTH-1:1]};
                shift     = 1'b1;
                shift_bit = q[0];
            end
            3'b110: begin
                q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                shift     = 1'b1;
                shift_bit = q[WIDTH-1];
            end
            3'b111: q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= RESET_VAL;
            carry   <= 1'b0;
            ser_out <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            q     <= en ? q_next : q;
            carry <= en & wrap;
            if (en && shift)
                ser_out <= shift_bit;
            // a wrap on the same edge as clr_ovf keeps the flag set
            if (en && wrap)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

    assign qn   = ~q;
    assign zero = (q == '0);

endmodule

// File: tb/tb_jk_counter_reg.sv
// Randomized + directed bench for jk_counter_reg against an
// arithmetic reference model (WIDTH=8, RESET_VAL=0).
module tb_jk_counter_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, en, ser_in, clr_ovf;
    logic [2:0]   mode;
    logic [W-1:0] j, k, d, q, qn;
    logic         carry, ser_out, ovf, zero;

    int errors = 0;
    int checks = 0;

    int mq, mc, ms, mo;

    always #5 clk = ~clk;

    jk_counter_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .j(j), .k(k), .d(d), .ser_in(ser_in), .clr_ovf(clr_ovf),
        .q(q), .qn(qn), .carry(carry), .ser_out(ser_out),
        .ovf(ovf), .zero(zero)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int  nq;
        bit  wrap;
        int  jb, kb, qb;
        if (reset) begin
            mq = 0; mc = 0; ms = 0; mo = 0;
            return;
        end
        nq   = mq;
        wrap = 0;
        if (en) begin
            case (int'(mode))
                0: begin
                    nq = 0;
                    for (int b = 0; b < W; b++) begin
                        jb = (int'(j) >> b) & 1;
                        kb = (int'(k) >> b) & 1;
                        qb = (mq >> b) & 1;
                        if (jb == 1 && kb == 1) qb = 1 - qb;
                        else if (jb == 1)       qb = 1;
                        else if (kb == 1)       qb = 0;
                        nq = nq + (qb << b);
                    end
                end
                1: nq = int'(d);
                2: begin nq = (mq + 1) % 256; wrap = (mq == 255); end
                3: begin nq = (mq + 255) % 256; wrap = (mq == 0); end
                4: begin ms = mq / 128; nq = (mq * 2 + int'(ser_in)) % 256; end
                5: begin ms = mq % 2; nq = mq / 2 + int'(ser_in) * 128; end
                6: begin ms = mq / 128; nq = (mq * 2 + mq / 128) % 256; end
                default: nq = mq;
            endcase
        end
        mc = wrap ? 1 : 0;
        if (wrap)         mo = 1;
        else if (clr_ovf) mo = 0;
        mq = nq;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("q",     32'(q),       32'(mq));
        chk("qn",    32'(qn),      32'(255 - mq));
        chk("carry", 32'(carry),   32'(mc));
        chk("ser",   32'(ser_out), 32'(ms));
        chk("ovf",   32'(ovf),     32'(mo));
        chk("zero",  32'(zero),    32'(mq == 0));
    endtask

    initial begin
        reset = 1; en = 0; mode = 0; j = 0; k = 0; d = 0;
        ser_in = 0; clr_ovf = 0;
        cyc();
        cyc();
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_qn", 32'(qn), 32'hFF);
        reset = 0;

        en = 1; mode = 3'b010;
        for (int i = 0; i < 256; i++) begin
            cyc();
            chk("up_q", 32'(q), 32'((i + 1) % 256));
            chk("up_carry", 32'(carry), 32'(i == 255));
        end
        chk("up_ovf", 32'(ovf), 32'd1);
        mode = 3'b111;
        cyc();
        chk("hold_carry", 32'(carry), 32'd0);
        chk("hold_ovf", 32'(ovf), 32'd1);

        clr_ovf = 1; mode = 3'b011;
        cyc();
        chk("dn_q", 32'(q), 32'hFF);
        chk("dn_carry", 32'(carry), 32'd1);
        chk("dn_ovf_setwins", 32'(ovf), 32'd1);
        en = 0; mode = 3'b010;
        cyc();
        chk("clr_noen", 32'(ovf), 32'd0);
        chk("noen_q", 32'(q), 32'hFF);
        clr_ovf = 0; en = 1;

        mode = 3'b001; d = 8'hA5; cyc();
        mode = 3'b000; j = 8'hF0; k = 8'h0F; cyc();
        chk("jk_setclr", 32'(q), 32'hF0);
        j = 8'hFF; k = 8'hFF; cyc();
        chk("jk_toggle", 32'(q), 32'h0F);
        j = 8'h00; k = 8'h00; cyc();
        chk("jk_hold", 32'(q), 32'h0F);

        mode = 3'b001; d = 8'h81; cyc();
        mode = 3'b100; ser_in = 0; cyc();
        chk("shl_q", 32'(q), 32'h02);
        chk("shl_so", 32'(ser_out), 32'd1);
        mode = 3'b110; cyc();
        chk("rol_q", 32'(q), 32'h04);
        chk("rol_so", 32'(ser_out), 32'd0);
        mode = 3'b101; ser_in = 1; cyc();
        chk("shr_q", 32'(q), 32'h82);
        chk("shr_so", 32'(ser_out), 32'd0);

        mode = 3'b001; d = 8'hFF; cyc();
        mode = 3'b010; cyc();
        chk("pre_ovf", 32'(ovf), 32'd1);
        mode = 3'b001; d = 8'hFE; cyc();
        mode = 3'b010; reset = 1; cyc();
        chk("abort_q", 32'(q), 32'h00);
        chk("abort_carry", 32'(carry), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        reset = 0; en = 0; mode = 3'b001; d = 8'h55; cyc();
        chk("en0_q", 32'(q), 32'h00);

        for (int n = 0; n < 600; n++) begin
            reset   = ($urandom_range(0, 40) == 0);
            en      = ($urandom_range(0, 3) != 0);
            mode    = 3'($urandom_range(0, 7));
            j       = 8'($urandom);
            k       = 8'($urandom);
            case ($urandom_range(0, 5))
                0: d = 8'hFF;
                1: d = 8'h00;
                2: d = 8'hFE;
                default: d = 8'($urandom);
            endcase
            ser_in  = 1'($urandom);
            clr_ovf = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
